// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: pipe-0 owns rf port 0, pipe-1 owns rf port 1, and a 2-entry mul/div buffer fills port 1 when pipe-1 leaves it free.
// Latency: pipe writes are combinational; a buffered mul/div result reaches the regfile at least 1 cycle after its push.
// Backpressure: md_ready drops while the buffer is full; a head that starves for STARVE_LIMIT cycles forces a one-cycle stall of pipe-1.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_we,
   input  logic [4:0]  p0_num,
   input  logic [31:0] p0_data,
   input  logic        p1_we,
   input  logic [4:0]  p1_num,
   input  logic [31:0] p1_data,
   input  logic        md_valid,
   input  logic [4:0]  md_num,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        rf_we0,
   output logic [4:0]  rf_num0,
   output logic [31:0] rf_data0,
   output logic        rf_we1,
   output logic [4:0]  rf_num1,
   output logic [31:0] rf_data1,
   output logic        stall_o,
   output logic        pending_o
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   // buffer storage and control state
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [1:0]       vld_q, vld_d;
   logic [1:0][4:0]  num_q, num_d;
   logic [1:0][31:0] data_q, data_d;
   logic [2:0]       starve_q, starve_d;
   logic             stall_q, stall_d;
   logic             pending_q, pending_d;

   // per-cycle decisions
   logic p0_wr;
   logic p1_wr;
   logic head_present;
   logic head_vld;
   logic head_live;
   logic head_wr;
   logic pop;
   logic push;
   logic push_hit;

   // Port arbitration, buffer pop/push, squash and starvation tracking.
   always_comb begin
      p0_wr        = p0_we && (p0_num != 5'd0);
      // during a forced stall pipe-1 neither writes nor squashes
      p1_wr        = p1_we && (p1_num != 5'd0) && !stall_q;
      head_present = (count_q != 2'd0);
      head_vld     = head_present && vld_q[rd_ptr_q];
      // a head hit by a same-cycle port-0 write is stale: drop it rather than write it alongside
      head_live    = head_vld && !(p0_wr && (num_q[rd_ptr_q] == p0_num));
      // buffered results are never written in a reset cycle so they are dropped cleanly
      head_wr      = rst && head_live && !p1_wr;
      // stale/invalid heads pop without needing the port
      pop          = head_present && (head_wr || !head_live);
      md_ready     = (count_q != 2'd2);
      // r0 results are accepted but never stored
      push         = md_valid && md_ready && (md_num != 5'd0);
      push_hit     = (p0_wr && (md_num == p0_num)) || (p1_wr && (md_num == p1_num));

      rf_we0   = p0_wr;
      rf_num0  = p0_wr ? p0_num  : 5'd0;
      rf_data0 = p0_wr ? p0_data : 32'd0;

      rf_we1   = p1_wr || head_wr;
      rf_num1  = 5'd0;
      rf_data1 = 32'd0;
      if (p1_wr) begin
         rf_num1  = p1_num;
         rf_data1 = p1_data;
      end else if (head_wr) begin
         rf_num1  = num_q[rd_ptr_q];
         rf_data1 = data_q[rd_ptr_q];
      end

      vld_d  = vld_q;
      num_d  = num_q;
      data_d = data_q;
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
      end
      // pipe writes are younger than anything buffered for the same register
      for (int i = 0; i < 2; i++) begin
         if ((p0_wr && (num_q[i] == p0_num)) || (p1_wr && (num_q[i] == p1_num))) begin
            vld_d[i] = 1'b0;
         end
      end
      if (push) begin
         num_d[wr_ptr_q]  = md_num;
         data_d[wr_ptr_q] = md_data;
         vld_d[wr_ptr_q]  = !push_hit;
      end

      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};

      // a head that is present but not popped is valid and was blocked by pipe-1
      starve_d = starve_q;
      if (pop || !head_present) begin
         starve_d = 3'd0;
      end else if (head_vld && !head_wr && (starve_q != LIMIT)) begin
         starve_d = starve_q + 3'd1;
      end

      // one-cycle pulse on the edge where the counter first reaches the limit
      stall_d   = (starve_d == LIMIT) && (starve_q != LIMIT);
      pending_d = |vld_d;

      stall_o   = stall_q;
      pending_o = pending_q;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         vld_q     <= 2'b00;
         num_q     <= '0;
         data_q    <= '0;
         starve_q  <= 3'd0;
         stall_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         vld_q     <= vld_d;
         num_q     <= num_d;
         data_q    <= data_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared 1 ns later, mid-cycle.
// The model tracks buffered results as a queue plus a starvation count.
module tb_wb_port_arbiter;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_we, p1_we, md_valid;
   logic [4:0]  p0_num, p1_num, md_num;
   logic [31:0] p0_data, p1_data, md_data;
   logic        md_ready, rf_we0, rf_we1, stall_o, pending_o;
   logic [4:0]  rf_num0, rf_num1;
   logic [31:0] rf_data0, rf_data1;

   always #5 clk = ~clk;

   wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .p0_we(p0_we), .p0_num(p0_num), .p0_data(p0_data),
      .p1_we(p1_we), .p1_num(p1_num), .p1_data(p1_data),
      .md_valid(md_valid), .md_num(md_num), .md_data(md_data),
      .md_ready(md_ready),
      .rf_we0(rf_we0), .rf_num0(rf_num0), .rf_data0(rf_data0),
      .rf_we1(rf_we1), .rf_num1(rf_num1), .rf_data1(rf_data1),
      .stall_o(stall_o), .pending_o(pending_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_stall  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   typedef struct {
      bit        vld;
      bit [4:0]  num;
      bit [31:0] data;
   } ent_t;

   ent_t q[$];
   int   starve = 0;
   bit   stall_m = 0;

   function automatic logic [4:0] rnd_num();
      int p = $urandom_range(0, 9);
      if (p > 7) return 5'($urandom_range(0, 31));
      return 5'(p);
   endfunction

   // One cycle: drive random inputs, compare against the model, advance the model.
   task automatic step(input int p0_pct, input int p1_pct, input int md_pct, input int rst_pct);
      bit   p0w, p1w, hw, popd, empty, accept, hit;
      int   nc;
      ent_t h;
      @(negedge clk);
      rst      = ($urandom_range(0, 99) < rst_pct) ? 1'b0 : 1'b1;
      p0_we    = ($urandom_range(0, 99) < p0_pct);
      p0_num   = rnd_num();
      p0_data  = $urandom;
      p1_we    = ($urandom_range(0, 99) < p1_pct);
      p1_num   = rnd_num();
      p1_data  = $urandom;
      md_valid = ($urandom_range(0, 99) < md_pct);
      md_num   = rnd_num();
      md_data  = $urandom;
      #1;

      p0w  = p0_we && (p0_num != 0);
      p1w  = p1_we && (p1_num != 0) && !stall_m;
      hw   = 0;
      popd = 0;
      h    = '{vld: 0, num: 0, data: 0};
      if (q.size() > 0) begin
         h = q[0];
         if (!h.vld || (p0w && h.num == p0_num)) popd = 1;
         else if (!p1w && rst) begin
            hw   = 1;
            popd = 1;
         end
      end

      check_eq("md_ready", md_ready, 32'(q.size() < 2));
      begin
         bit pend = 0;
         foreach (q[i]) if (q[i].vld) pend = 1;
         check_eq("pending_o", pending_o, 32'(pend));
      end
      check_eq("stall_o", stall_o, 32'(stall_m));
      if (stall_o) n_stall++;
      check_eq("rf_we0", rf_we0, 32'(p0w));
      if (p0w) begin
         check_eq("rf_num0", rf_num0, 32'(p0_num));
         check_eq("rf_data0", rf_data0, p0_data);
      end
      check_eq("rf_we1", rf_we1, 32'(p1w || hw));
      if (p1w) begin
         check_eq("rf_num1_p1", rf_num1, 32'(p1_num));
         check_eq("rf_data1_p1", rf_data1, p1_data);
      end else if (hw) begin
         check_eq("rf_num1_md", rf_num1, 32'(h.num));
         check_eq("rf_data1_md", rf_data1, h.data);
      end

      if (!rst) begin
         q.delete();
         starve  = 0;
         stall_m = 0;
      end else begin
         empty  = (q.size() == 0);
         accept = md_valid && (q.size() < 2);
         if (popd) void'(q.pop_front());
         foreach (q[i])
            if ((p0w && q[i].num == p0_num) || (p1w && q[i].num == p1_num)) q[i].vld = 0;
         if (accept && md_num != 0) begin
            hit = (p0w && md_num == p0_num) || (p1w && md_num == p1_num);
            q.push_back('{vld: !hit, num: md_num, data: md_data});
         end
         nc      = (popd || empty) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
         stall_m = (nc == LIMIT) && (starve != LIMIT);
         starve  = nc;
      end
   endtask

   initial begin
      rst = 1'b0;
      p0_we = 0; p0_num = 0; p0_data = 0;
      p1_we = 0; p1_num = 0; p1_data = 0;
      md_valid = 0; md_num = 0; md_data = 0;
      repeat (2) @(posedge clk);

      // quiet cycles: reset state
      repeat (3) step(0, 0, 0, 0);
      // pipe-1 dominates: buffer fills, starvation stalls
      repeat (400) step(15, 92, 35, 0);
      // balanced traffic with occasional resets
      repeat (400) step(40, 50, 60, 3);
      // mostly mul/div traffic: buffer drains through port 1, lots of squash/r0 cases
      repeat (400) step(50, 20, 80, 0);
      // mixed load with resets while buffered
      repeat (400) step(30, 80, 70, 4);

      check_eq("stall_seen", 32'(n_stall > 0), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
